// File: rtl/nfc_pkg.sv
// Shared definitions for the NAND flash A->B page copy engine: FSM states,
// flash command codes, strobe/guard timing constants and address-byte helper.
package nfc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    A_CMD,
    A_ADDR,
    A_WAIT,
    A_READ,
    B_CMD,
    B_ADDR,
    B_DATA,
    B_CONF,
    B_WAIT,
    B_STAT,
    NEXT,
    DONE
  } nfc_state_e;

  localparam logic [7:0] CMD_READ    = 8'h00;
  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_STATUS  = 8'h70;

  // Each strobe is one low cycle followed by one high cycle.
  localparam int unsigned STROBE_CYCLES = 2;
  // Cycles RB is ignored after the last strobe before a busy wait.
  localparam int unsigned GUARD_CYCLES  = 2;

  // Address byte idx: 0 is the column (always 0), 1.. are row bytes LSB first.
  function automatic logic [7:0] addr_byte(input logic [15:0] page, input logic [1:0] idx);
    case (idx)
      2'd1:    return page[7:0];
      2'd2:    return page[15:8];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/nfc_page_buf.sv
// Single-port synchronous page buffer, DEPTH x 8, one-cycle read latency.
// Contents are deliberately not reset.
module nfc_page_buf #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/nfc_copy_engine.sv
// Copies PAGE_NUM pages from NAND device A to device B through a page buffer.
// Define NFC_STATUS_EN to read back program status (70h) and flag failures on err.
module nfc_copy_engine
  import nfc_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = 512,
  parameter int unsigned PAGE_NUM   = 512,
  parameter int unsigned ROW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic       err,
  inout  logic [7:0] F_IO_A,
  output logic       F_CLE_A,
  output logic       F_ALE_A,
  output logic       F_REN_A,
  output logic       F_WEN_A,
  input  logic       F_RB_A,
  inout  logic [7:0] F_IO_B,
  output logic       F_CLE_B,
  output logic       F_ALE_B,
  output logic       F_REN_B,
  output logic       F_WEN_B,
  input  logic       F_RB_B
);

  localparam int unsigned BW        = $clog2(PAGE_BYTES);
  localparam logic [BW-1:0] LAST_COL  = BW'(PAGE_BYTES - 1);
  localparam logic [15:0]   LAST_PAGE = 16'(PAGE_NUM - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(ROW_CYCLES);
  localparam logic [1:0]    GUARD     = 2'(GUARD_CYCLES);

  nfc_state_e     state_q, state_d;
  logic           ph_q, ph_d;
  logic [1:0]     idx_q, idx_d;
  logic [1:0]     gd_q, gd_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic [15:0]    page_q, page_d;

  logic           cle_a, ale_a, wen_a, ren_a, oe_a;
  logic           cle_b, ale_b, wen_b, ren_b, oe_b;
  logic [7:0]     dout_a, dout_b;
  logic           ram_we;
  logic [BW-1:0]  ram_addr;
  logic [7:0]     ram_wdata, ram_rdata;

`ifdef NFC_STATUS_EN
  logic err_q, err_d;
`endif

  nfc_page_buf #(
    .DEPTH (PAGE_BYTES),
    .AW    (BW)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      idx_q   <= '0;
      gd_q    <= '0;
      cnt_q   <= '0;
      page_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      gd_q    <= gd_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
    end
  end

`ifdef NFC_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_io_b;
  assign unused_io_b = ^F_IO_B;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    gd_d      = gd_q;
    cnt_d     = cnt_q;
    page_d    = page_q;
`ifdef NFC_STATUS_EN
    err_d     = err_q;
`endif
    cle_a     = 1'b0;
    ale_a     = 1'b0;
    wen_a     = 1'b1;
    ren_a     = 1'b1;
    oe_a      = 1'b0;
    dout_a    = '0;
    cle_b     = 1'b0;
    ale_b     = 1'b0;
    wen_b     = 1'b1;
    ren_b     = 1'b1;
    oe_b      = 1'b0;
    dout_b    = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = A_CMD;
          ph_d    = 1'b0;
          idx_d   = '0;
          gd_d    = '0;
          cnt_d   = '0;
          page_d  = '0;
        end
      end

      A_CMD: begin
        cle_a  = 1'b1;
        oe_a   = 1'b1;
        dout_a = CMD_READ;
        wen_a  = ph_q;
        ph_d   = ~ph_q;
        if (ph_q) begin
          state_d = A_ADDR;
          idx_d   = '0;
        end
      end

      A_ADDR: begin
        ale_a  = 1'b1;
        oe_a   = 1'b1;
        dout_a = addr_byte(page_q, idx_q);
        wen_a  = ph_q;
        ph_d   = ~ph_q;
        if (ph_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = A_WAIT;
            idx_d   = '0;
            gd_d    = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      A_WAIT: begin
        if (gd_q < GUARD) begin
          gd_d = gd_q + 2'd1;
        end else if (F_RB_A) begin
          state_d = A_READ;
          ph_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      // Byte is captured into the buffer at the edge ending the REN-low cycle.
      A_READ: begin
        ren_a     = ph_q;
        ram_we    = ~ph_q;
        ram_addr  = cnt_q;
        ram_wdata = F_IO_A;
        ph_d      = ~ph_q;
        if (ph_q) begin
          if (cnt_q == LAST_COL) begin
            state_d = B_CMD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      B_CMD: begin
        cle_b  = 1'b1;
        oe_b   = 1'b1;
        dout_b = CMD_PROG;
        wen_b  = ph_q;
        ph_d   = ~ph_q;
        if (ph_q) begin
          state_d = B_ADDR;
          idx_d   = '0;
        end
      end

      B_ADDR: begin
        ale_b  = 1'b1;
        oe_b   = 1'b1;
        dout_b = addr_byte(page_q, idx_q);
        wen_b  = ph_q;
        ph_d   = ~ph_q;
        if (ph_q) begin
          if (idx_q == LAST_IDX) begin
            state_d = B_DATA;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      // The high cycle prefetches the next byte so read latency is hidden;
      // the address wrap on the final byte only performs a harmless read.
      B_DATA: begin
        oe_b     = 1'b1;
        dout_b   = ram_rdata;
        wen_b    = ph_q;
        ram_addr = cnt_q + BW'(ph_q);
        ph_d     = ~ph_q;
        if (ph_q) begin
          if (cnt_q == LAST_COL) begin
            state_d = B_CONF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      B_CONF: begin
        cle_b  = 1'b1;
        oe_b   = 1'b1;
        dout_b = CMD_CONFIRM;
        wen_b  = ph_q;
        ph_d   = ~ph_q;
        if (ph_q) begin
          state_d = B_WAIT;
          gd_d    = '0;
        end
      end

      B_WAIT: begin
        if (gd_q < GUARD) begin
          gd_d = gd_q + 2'd1;
        end else if (F_RB_B) begin
`ifdef NFC_STATUS_EN
          state_d = B_STAT;
`else
          state_d = NEXT;
`endif
          ph_d    = 1'b0;
          idx_d   = '0;
        end
      end

`ifdef NFC_STATUS_EN
      // idx 0: write 70h; idx 1: one read strobe returning the status byte.
      B_STAT: begin
        ph_d = ~ph_q;
        if (idx_q == 2'd0) begin
          cle_b  = 1'b1;
          oe_b   = 1'b1;
          dout_b = CMD_STATUS;
          wen_b  = ph_q;
          if (ph_q) begin
            idx_d = 2'd1;
          end
        end else begin
          ren_b = ph_q;
          if (!ph_q && F_IO_B[0]) begin
            err_d = 1'b1;
          end
          if (ph_q) begin
            state_d = NEXT;
            idx_d   = '0;
          end
        end
      end
`endif

      NEXT: begin
        if (page_q == LAST_PAGE) begin
          state_d = DONE;
        end else begin
          page_d  = page_q + 16'd1;
          state_d = A_CMD;
          ph_d    = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE) && (state_q != DONE);

  assign F_CLE_A = cle_a;
  assign F_ALE_A = ale_a;
  assign F_WEN_A = wen_a;
  assign F_REN_A = ren_a;
  assign F_IO_A  = oe_a ? dout_a : 'z;

  assign F_CLE_B = cle_b;
  assign F_ALE_B = ale_b;
  assign F_WEN_B = wen_b;
  assign F_REN_B = ren_b;
  assign F_IO_B  = oe_b ? dout_b : 'z;

endmodule

// File: tb/tb_nfc_copy_engine.sv
// Directed bench for nfc_copy_engine with behavioural NAND models on both buses.
module tb_nfc_copy_engine;

  localparam int unsigned PB = 16;
  localparam int unsigned PN = 2;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done, busy, err;
  wire  [7:0] F_IO_A, F_IO_B;
  logic F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A, F_RB_A;
  logic F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B, F_RB_B;

  int ncmp = 0;
  int nfail = 0;

  logic       tb_clr = 1'b1;
  logic       tb_drv = 1'b1;
  logic [7:0] tb_pat = 8'h5A;

  always #5 clk = ~clk;

  nfc_copy_engine #(
    .PAGE_BYTES (PB),
    .PAGE_NUM   (PN),
    .ROW_CYCLES (RC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .done    (done),
    .busy    (busy),
    .err     (err),
    .F_IO_A  (F_IO_A),
    .F_CLE_A (F_CLE_A),
    .F_ALE_A (F_ALE_A),
    .F_REN_A (F_REN_A),
    .F_WEN_A (F_WEN_A),
    .F_RB_A  (F_RB_A),
    .F_IO_B  (F_IO_B),
    .F_CLE_B (F_CLE_B),
    .F_ALE_B (F_ALE_B),
    .F_REN_B (F_REN_B),
    .F_WEN_B (F_WEN_B),
    .F_RB_B  (F_RB_B)
  );

  // ---------------- flash A model (source, byte = page ^ col) ----------------
  logic [7:0] a_cmd;
  logic [7:0] a_addr [3];
  logic [7:0] a_io_p;
  logic       a_rb, a_wen_p, a_ren_p, a_await;
  int a_ai, a_col, a_busy, a_rise, a_lat_max, cyc;
  int a_wen_viol, a_ren_viol, a_io_viol, a_busy_ren, a_rd_cnt;

  assign F_RB_A = a_rb;
  assign F_IO_A = !F_REN_A ? (a_addr[1] ^ 8'(a_col)) : (tb_drv ? tb_pat : 8'hzz);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tb_clr) begin
      a_cmd <= 8'hFF;
      a_addr[0] <= '0; a_addr[1] <= '0; a_addr[2] <= '0;
      a_io_p <= '0; a_rb <= 1'b1; a_wen_p <= 1'b1; a_ren_p <= 1'b1; a_await <= 1'b0;
      a_ai <= 0; a_col <= 0; a_busy <= 0; a_rise <= 0; a_lat_max <= 0;
      a_wen_viol <= 0; a_ren_viol <= 0; a_io_viol <= 0; a_busy_ren <= 0; a_rd_cnt <= 0;
    end else begin
      a_wen_p <= F_WEN_A;
      a_ren_p <= F_REN_A;
      if (!F_WEN_A) begin
        a_io_p <= F_IO_A;
        if (!a_wen_p) a_wen_viol <= a_wen_viol + 1;
        if (F_CLE_A) begin
          a_cmd <= F_IO_A; a_ai <= 0; a_col <= 0;
        end else if (F_ALE_A) begin
          if (a_ai < 3) a_addr[a_ai] <= F_IO_A;
          a_ai <= a_ai + 1;
          if (a_ai == RC) begin a_busy <= 50; a_rb <= 1'b0; end
        end
      end else if (!a_wen_p && F_IO_A !== a_io_p) begin
        a_io_viol <= a_io_viol + 1;
      end
      if (a_busy > 0) begin
        a_busy <= a_busy - 1;
        if (a_busy == 1) begin a_rb <= 1'b1; a_rise <= cyc; a_await <= 1'b1; end
      end
      if (!F_REN_A) begin
        a_rd_cnt <= a_rd_cnt + 1;
        if (!a_ren_p) a_ren_viol <= a_ren_viol + 1;
        if (!a_rb) a_busy_ren <= a_busy_ren + 1;
        if (a_await) begin
          a_await <= 1'b0;
          if (cyc - a_rise > a_lat_max) a_lat_max <= cyc - a_rise;
        end
      end else if (!a_ren_p) begin
        a_col <= a_col + 1;
      end
    end
  end

  // ---------------- flash B model (destination) ----------------
  logic [7:0] b_mem [32];
  logic [7:0] b_addr [3];
  logic [7:0] b_lastpg;
  logic       b_rb, b_wen_p, b_ren_p;
  int b_ai, b_col, b_busy, b_prog, b_stat, b_dcnt, b_wen_viol, b_ren_viol, b_busy_wr;
  int both_viol, done_cnt, done_busy;

  assign F_RB_B = b_rb;
  assign F_IO_B = !F_REN_B ? ((b_lastpg == 8'h00) ? 8'h01 : 8'h00) : (tb_drv ? tb_pat : 8'hzz);

  always @(negedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 32; i++) b_mem[i] <= 8'hFF;
      b_addr[0] <= '0; b_addr[1] <= '0; b_addr[2] <= '0;
      b_lastpg <= 8'hFF; b_rb <= 1'b1; b_wen_p <= 1'b1; b_ren_p <= 1'b1;
      b_ai <= 0; b_col <= 0; b_busy <= 0; b_prog <= 0; b_stat <= 0; b_dcnt <= 0;
      b_wen_viol <= 0; b_ren_viol <= 0; b_busy_wr <= 0;
      both_viol <= 0; done_cnt <= 0; done_busy <= 0;
    end else begin
      b_wen_p <= F_WEN_B;
      b_ren_p <= F_REN_B;
      if (!F_WEN_B) begin
        if (!b_wen_p) b_wen_viol <= b_wen_viol + 1;
        if (!b_rb) b_busy_wr <= b_busy_wr + 1;
        if (F_CLE_B) begin
          case (F_IO_B)
            8'h80: begin b_col <= 0; b_ai <= 0; end
            8'h10: begin b_prog <= b_prog + 1; b_busy <= 10; b_rb <= 1'b0; b_lastpg <= b_addr[1]; end
            8'h70: b_stat <= b_stat + 1;
            default: ;
          endcase
        end else if (F_ALE_B) begin
          if (b_ai < 3) b_addr[b_ai] <= F_IO_B;
          b_ai <= b_ai + 1;
        end else begin
          b_mem[{b_addr[1][0], 4'(b_col)}] <= F_IO_B;
          b_col <= b_col + 1;
          b_dcnt <= b_dcnt + 1;
        end
      end
      if (!F_REN_B && !b_ren_p) b_ren_viol <= b_ren_viol + 1;
      if (b_busy > 0) begin
        b_busy <= b_busy - 1;
        if (b_busy == 1) b_rb <= 1'b1;
      end
      if ((!F_WEN_A || !F_REN_A || F_CLE_A || F_ALE_A) &&
          (!F_WEN_B || !F_REN_B || F_CLE_B || F_ALE_B)) both_viol <= both_viol + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        if (busy) done_busy <= done_busy + 1;
      end
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chkI(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_cle_a"}, F_CLE_A, 1'b0);
    chk1({tag, "_ale_a"}, F_ALE_A, 1'b0);
    chk1({tag, "_wen_a"}, F_WEN_A, 1'b1);
    chk1({tag, "_ren_a"}, F_REN_A, 1'b1);
    chk1({tag, "_cle_b"}, F_CLE_B, 1'b0);
    chk1({tag, "_ale_b"}, F_ALE_B, 1'b0);
    chk1({tag, "_wen_b"}, F_WEN_B, 1'b1);
    chk1({tag, "_ren_b"}, F_REN_B, 1'b1);
    chk8({tag, "_io_a_hiz"}, F_IO_A, 8'h5A);
    chk8({tag, "_io_b_hiz"}, F_IO_B, 8'h5A);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk1({tag, "_done_seen"}, done, 1'b1);
    chk1({tag, "_busy_with_done"}, busy, 1'b0);
    @(negedge clk);
    chk1({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic check_copy(input string tag);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 16; c++) begin
        chk8($sformatf("%s_b_data[%0d]", tag, p * 16 + c), b_mem[p * 16 + c], 8'(p ^ c));
      end
    end
    chkI({tag, "_programs"}, b_prog, 2);
    chkI({tag, "_a_reads"}, a_rd_cnt, 32);
    chkI({tag, "_done_pulses"}, done_cnt, 1);
    chkI({tag, "_busy_during_done"}, done_busy, 0);
    chkI({tag, "_both_active"}, both_viol, 0);
    chkI({tag, "_b_wen_width"}, b_wen_viol, 0);
    chkI({tag, "_b_ren_width"}, b_ren_viol, 0);
    chkI({tag, "_b_write_busy"}, b_busy_wr, 0);
`ifdef NFC_STATUS_EN
    chkI({tag, "_status_cmds"}, b_stat, 2);
    chk1({tag, "_err"}, err, 1'b1);
`else
    chkI({tag, "_status_cmds"}, b_stat, 0);
    chk1({tag, "_err"}, err, 1'b0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk_idle_bus("reset");

    rst_n  = 1'b1;
    tb_drv = 1'b0;
    tb_clr = 1'b0;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("run_busy", busy, 1'b1);
    chk1("a_cmd_cle", F_CLE_A, 1'b1);
    chk1("a_cmd_wen", F_WEN_A, 1'b0);
    chk8("a_cmd_io", F_IO_A, 8'h00);

    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    wait_done("run1");
    repeat (5) @(negedge clk);
    check_copy("run1");
    chk8("a_p1_cmd", a_cmd, 8'h00);
    chk8("a_p1_col", a_addr[0], 8'h00);
    chk8("a_p1_row0", a_addr[1], 8'h01);
    chk8("a_p1_row1", a_addr[2], 8'h00);
    chkI("a_p1_addr_bytes", a_ai, 3);
    chkI("a_wen_width", a_wen_viol, 0);
    chkI("a_ren_width", a_ren_viol, 0);
    chkI("a_io_stable", a_io_viol, 0);
    chkI("a_ren_while_busy", a_busy_ren, 0);
    chk1("a_read_latency", (a_lat_max >= 1 && a_lat_max <= 2), 1'b1);
    chk1("idle_after_run", busy, 1'b0);

    // Abort in the middle of B_DATA for page 0.
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    begin
      int t;
      t = 0;
      while (b_dcnt < 3 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk1("reached_b_data", (b_dcnt >= 3), 1'b1);
    end
    chk1("mid_b_data_page0", b_addr[1] == 8'h00 && b_prog == 0, 1'b1);
    #2;
    rst_n  = 1'b0;
    tb_drv = 1'b1;
    #1;
    chk_idle_bus("async_reset");
    repeat (3) @(negedge clk);
    chk_idle_bus("held_reset");

    rst_n  = 1'b1;
    tb_drv = 1'b0;
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk8("restart_a_cmd", F_IO_A, 8'h00);
    wait_done("run2");
    repeat (5) @(negedge clk);
    check_copy("run2");

    repeat (10) @(negedge clk);
`ifdef NFC_STATUS_EN
    chk1("err_sticky", err, 1'b1);
`else
    chk1("err_tied", err, 1'b0);
`endif
    chk1("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
